// File: rtl/rnds_dispatch_ctrl_if.sv
// Rename/dispatch handshake bundle: renamed-slot descriptors and resource
// status flow into the controller, grants and store IDs flow back out.
interface rnds_dispatch_ctrl_if #(
    parameter int unsigned STORE_ID_WIDTH = 4
);
    // Slot descriptors
    logic                      instr0_valid;
    logic                      instr1_valid;
    logic                      instr0_is_mem;
    logic                      instr1_is_mem;
    logic                      instr0_is_store;
    logic                      instr1_is_store;
    logic                      instr0_is_serial;
    logic                      instr1_is_serial;
    // Resource status
    logic                      rob_instr0_check_top;
    logic                      rob_instr1_check_top;
    logic                      rob_is_empty;
    logic                      int_iq_instr0_check_top;
    logic                      int_iq_instr1_check_top;
    logic                      mem_iq_instr0_check_top;
    logic                      mem_iq_instr1_check_top;
    // Store retirement and recovery
    logic                      store_commit;
    logic                      flush;
    logic [STORE_ID_WIDTH:0]   flush_store_cnt;
    // Grants and allocation results
    logic                      instr0_req;
    logic                      instr1_req;
    logic                      int_pack0_valid;
    logic                      int_pack1_valid;
    logic                      mem_pack0_valid;
    logic                      mem_pack1_valid;
    logic [STORE_ID_WIDTH-1:0] instr0_store_id;
    logic [STORE_ID_WIDTH-1:0] instr1_store_id;
    logic                      rnds_stall;
    logic [1:0]                ctrl_state;

    modport master (
        output instr0_valid, instr1_valid, instr0_is_mem, instr1_is_mem,
               instr0_is_store, instr1_is_store, instr0_is_serial, instr1_is_serial,
               rob_instr0_check_top, rob_instr1_check_top, rob_is_empty,
               int_iq_instr0_check_top, int_iq_instr1_check_top,
               mem_iq_instr0_check_top, mem_iq_instr1_check_top,
               store_commit, flush, flush_store_cnt,
        input  instr0_req, instr1_req, int_pack0_valid, int_pack1_valid,
               mem_pack0_valid, mem_pack1_valid, instr0_store_id, instr1_store_id,
               rnds_stall, ctrl_state
    );

    modport slave (
        input  instr0_valid, instr1_valid, instr0_is_mem, instr1_is_mem,
               instr0_is_store, instr1_is_store, instr0_is_serial, instr1_is_serial,
               rob_instr0_check_top, rob_instr1_check_top, rob_is_empty,
               int_iq_instr0_check_top, int_iq_instr1_check_top,
               mem_iq_instr0_check_top, mem_iq_instr1_check_top,
               store_commit, flush, flush_store_cnt,
        output instr0_req, instr1_req, int_pack0_valid, int_pack1_valid,
               mem_pack0_valid, mem_pack1_valid, instr0_store_id, instr1_store_id,
               rnds_stall, ctrl_state
    );
endinterface

// File: rtl/rnds_dispatch_ctrl.sv
// Two-wide in-order dispatch controller: grants 0/1/2 renamed instructions per
// cycle against ROB, IQ and store-ID availability, owns the store-ID counter,
// and sequences serializing instructions and flush recovery.
module rnds_dispatch_ctrl #(
    parameter int unsigned STORE_ID_WIDTH = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    rnds_dispatch_ctrl_if.slave bus
);
    localparam int unsigned W  = STORE_ID_WIDTH;
    localparam int unsigned CW = STORE_ID_WIDTH + 1;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        SERIAL_WAIT = 2'd1,
        FLUSH       = 2'd2
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   store_cnt_q, store_cnt_d;
    logic [CW-1:0]   commit_ptr_q, commit_ptr_d;
    logic [CW-1:0]   inflight, free_ids, pair_stores, granted_stores;
    logic            ids_full, iq0_ok, iq1_ok, g0, g1;

    // Grant evaluation; slot 1 only rides along with slot 0 to keep program order
    always_comb begin
        inflight    = store_cnt_q - commit_ptr_q;
        ids_full    = (inflight == CW'(1 << W));
        free_ids    = CW'(1 << W) - inflight;
        pair_stores = CW'(bus.instr0_is_store) + CW'(bus.instr1_is_store);

        iq0_ok = bus.instr0_is_mem ? bus.mem_iq_instr0_check_top
                                   : bus.int_iq_instr0_check_top;
        // Same target IQ needs two free entries there; split targets need one each
        if (bus.instr0_is_mem == bus.instr1_is_mem)
            iq1_ok = bus.instr1_is_mem ? bus.mem_iq_instr1_check_top
                                       : bus.int_iq_instr1_check_top;
        else
            iq1_ok = bus.instr1_is_mem ? bus.mem_iq_instr0_check_top
                                       : bus.int_iq_instr0_check_top;

        g0 = bus.instr0_valid && (state_q == RUN) && !bus.flush
             && bus.rob_instr0_check_top && iq0_ok
             && (!bus.instr0_is_serial || bus.rob_is_empty)
             && (!bus.instr0_is_store || !ids_full);

        g1 = g0 && bus.instr1_valid
             && !bus.instr0_is_serial && !bus.instr1_is_serial
             && bus.rob_instr1_check_top && iq1_ok
             && (pair_stores <= free_ids);

        granted_stores = CW'(g0 && bus.instr0_is_store) + CW'(g1 && bus.instr1_is_store);
        commit_ptr_d   = commit_ptr_q + CW'(bus.store_commit);
        store_cnt_d    = bus.flush ? bus.flush_store_cnt : store_cnt_q + granted_stores;
    end

    assign bus.instr0_req      = g0;
    assign bus.instr1_req      = g1;
    assign bus.int_pack0_valid = g0 && !bus.instr0_is_mem;
    assign bus.int_pack1_valid = g1 && !bus.instr1_is_mem;
    assign bus.mem_pack0_valid = g0 && bus.instr0_is_mem;
    assign bus.mem_pack1_valid = g1 && bus.instr1_is_mem;
    assign bus.instr0_store_id = store_cnt_q[W-1:0];
    assign bus.instr1_store_id = store_cnt_q[W-1:0] + W'(g0 && bus.instr0_is_store);
    assign bus.rnds_stall      = (bus.instr0_valid && !g0) || (bus.instr1_valid && !g1);
    assign bus.ctrl_state      = state_q;

    // Control FSM and store-ID counters; flush overrides every other transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            store_cnt_q  <= '0;
            commit_ptr_q <= '0;
        end else begin
            store_cnt_q  <= store_cnt_d;
            commit_ptr_q <= commit_ptr_d;
            if (bus.flush) begin
                state_q <= FLUSH;
            end else begin
                unique case (state_q)
                    RUN:         if (g0 && bus.instr0_is_serial) state_q <= SERIAL_WAIT;
                    SERIAL_WAIT: if (bus.rob_is_empty) state_q <= RUN;
                    FLUSH:       state_q <= RUN;
                    default:     state_q <= RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rnds_dispatch_ctrl.sv
// Bench for rnds_dispatch_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a resource-counting model.
module tb_rnds_dispatch_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rnds_dispatch_ctrl_if #(.STORE_ID_WIDTH(4)) bus ();
    rnds_dispatch_ctrl #(.STORE_ID_WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: states RUN=0, SERIAL_WAIT=1, FLUSH=2; counters mod 32
    int m_state = 0, m_cnt = 0, m_cmt = 0;
    int robf, intf, memf, infl, freeid, n, umem, st0, st1, nst;
    logic [6:0] exp_v, act_v;

    function automatic int lvl(input logic one, input logic two);
        return two ? 2 : (one ? 1 : 0);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_cmt = 0;
        end else begin
            robf   = lvl(bus.rob_instr0_check_top, bus.rob_instr1_check_top);
            intf   = lvl(bus.int_iq_instr0_check_top, bus.int_iq_instr1_check_top);
            memf   = lvl(bus.mem_iq_instr0_check_top, bus.mem_iq_instr1_check_top);
            infl   = (m_cnt - m_cmt + 32) % 32;
            freeid = 16 - infl;
            st0    = int'(bus.instr0_is_store);
            st1    = int'(bus.instr1_is_store);
            n = 0;
            if (m_state == 0 && !bus.flush && bus.instr0_valid && robf >= 1
                && (bus.instr0_is_mem ? memf : intf) >= 1
                && (!bus.instr0_is_serial || bus.rob_is_empty) && st0 <= freeid) begin
                n = 1;
                umem = int'(bus.instr0_is_mem) + int'(bus.instr1_is_mem);
                if (bus.instr1_valid && !bus.instr0_is_serial && !bus.instr1_is_serial
                    && robf >= 2 && umem <= memf && (2 - umem) <= intf
                    && st0 + st1 <= freeid)
                    n = 2;
            end
            exp_v = {n >= 1, n >= 2,
                     n >= 1 && !bus.instr0_is_mem, n >= 2 && !bus.instr1_is_mem,
                     n >= 1 && bus.instr0_is_mem,  n >= 2 && bus.instr1_is_mem,
                     (bus.instr0_valid && n < 1) || (bus.instr1_valid && n < 2)};
            act_v = {bus.instr0_req, bus.instr1_req, bus.int_pack0_valid, bus.int_pack1_valid,
                     bus.mem_pack0_valid, bus.mem_pack1_valid, bus.rnds_stall};
            chk("grants", 32'(act_v), 32'(exp_v));
            chk("id0", 32'(bus.instr0_store_id), m_cnt % 16);
            chk("id1", 32'(bus.instr1_store_id), (m_cnt + ((n >= 1) ? st0 : 0)) % 16);
            chk("state", 32'(bus.ctrl_state), m_state);
            chk("store_cnt", 32'(dut.store_cnt_q), m_cnt);
            chk("commit_ptr", 32'(dut.commit_ptr_q), m_cmt);
            nst   = ((n >= 1) ? st0 : 0) + ((n >= 2) ? st1 : 0);
            m_cmt = (m_cmt + int'(bus.store_commit)) % 32;
            if (bus.flush) begin
                m_state = 2;
                m_cnt   = int'(bus.flush_store_cnt);
            end else begin
                m_cnt = (m_cnt + nst) % 32;
                if (m_state == 0 && n >= 1 && bus.instr0_is_serial) m_state = 1;
                else if (m_state == 1 && bus.rob_is_empty) m_state = 0;
                else if (m_state == 2) m_state = 0;
            end
        end
    end

    task automatic idle();
        bus.instr0_valid = 0; bus.instr1_valid = 0;
        bus.instr0_is_mem = 0; bus.instr1_is_mem = 0;
        bus.instr0_is_store = 0; bus.instr1_is_store = 0;
        bus.instr0_is_serial = 0; bus.instr1_is_serial = 0;
        bus.rob_instr0_check_top = 1; bus.rob_instr1_check_top = 1; bus.rob_is_empty = 1;
        bus.int_iq_instr0_check_top = 1; bus.int_iq_instr1_check_top = 1;
        bus.mem_iq_instr0_check_top = 1; bus.mem_iq_instr1_check_top = 1;
        bus.store_commit = 0; bus.flush = 0; bus.flush_store_cnt = '0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic lvl_bits(output logic one, output logic two);
        int r;
        r = int'($urandom_range(0, 5));
        one = (r != 0);
        two = (r >= 2);
    endtask

    initial begin
        int inf;
        rst_n = 0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("rst_req0", 32'(bus.instr0_req), 0);
        chk("rst_stall", 32'(bus.rnds_stall), 0);
        chk("rst_id0", 32'(bus.instr0_store_id), 0);
        chk("rst_state", 32'(bus.ctrl_state), 0);
        nxt();
        // Dual INT dispatch
        bus.instr0_valid = 1; bus.instr1_valid = 1;
        #1;
        chk("t1_req", {bus.instr0_req, bus.instr1_req}, 2'b11);
        chk("t1_int", {bus.int_pack0_valid, bus.int_pack1_valid}, 2'b11);
        chk("t1_mem", {bus.mem_pack0_valid, bus.mem_pack1_valid}, 2'b00);
        chk("t1_stall", 32'(bus.rnds_stall), 0);
        nxt();
        // Same-IQ limit, then split IQs
        bus.instr0_is_mem = 1; bus.instr1_is_mem = 1; bus.mem_iq_instr1_check_top = 0;
        #1;
        chk("t2_req", {bus.instr0_req, bus.instr1_req, bus.mem_pack0_valid}, 3'b101);
        chk("t2_stall", 32'(bus.rnds_stall), 1);
        bus.instr1_is_mem = 0;
        #1;
        chk("t2b_req", {bus.instr0_req, bus.instr1_req, bus.int_pack1_valid}, 3'b111);
        chk("t2b_stall", 32'(bus.rnds_stall), 0);
        nxt();
        // Store IDs: fill 16, 17th stalls, commit frees one
        idle();
        bus.instr0_valid = 1; bus.instr0_is_store = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t3_fill", {31'(bus.instr0_store_id), bus.instr0_req}, {31'(i), 1'b1});
            nxt();
        end
        #1;
        chk("t3_full", {bus.instr0_req, bus.rnds_stall}, 2'b01);
        bus.store_commit = 1;
        nxt();
        bus.store_commit = 0;
        #1;
        chk("t3_after", {28'(bus.instr0_store_id), bus.instr0_req}, {28'd0, 1'b1});
        nxt();
        bus.instr0_valid = 0; bus.store_commit = 1;
        repeat (16) nxt();
        bus.store_commit = 0; bus.instr0_valid = 1;
        for (int k = 0; k < 15; k++) begin
            #1;
            chk("t3_wrap", 32'(bus.instr0_store_id), (17 + k) % 16);
            nxt();
        end
        bus.instr0_valid = 0;
        #1;
        chk("t3_cnt0", 32'(dut.store_cnt_q), 0);
        nxt();
        // Serial instruction
        idle();
        bus.instr0_valid = 1; bus.instr0_is_serial = 1; bus.instr1_valid = 1; bus.rob_is_empty = 0;
        #1;
        chk("t4_wait", {bus.instr0_req, bus.rnds_stall}, 2'b01);
        bus.rob_is_empty = 1;
        #1;
        chk("t4_grant", {bus.instr0_req, bus.instr1_req, bus.rnds_stall}, 3'b101);
        nxt();
        bus.instr0_is_serial = 0; bus.rob_is_empty = 0;
        #1;
        chk("t4_sw", {30'(bus.ctrl_state), bus.instr0_req, bus.rnds_stall}, {30'd1, 2'b01});
        nxt();
        bus.rob_is_empty = 1;
        #1;
        chk("t4_sw2", {30'(bus.ctrl_state), bus.instr0_req}, {30'd1, 1'b0});
        nxt();
        #1;
        chk("t4_run", {30'(bus.ctrl_state), bus.instr0_req, bus.instr1_req}, {30'd0, 2'b11});
        nxt();
        // Flush with concurrent dispatch and commit
        rst_n = 0; idle();
        nxt();
        rst_n = 1;
        bus.instr0_valid = 1; bus.instr0_is_store = 1; bus.instr1_valid = 1; bus.instr1_is_store = 1;
        nxt();
        bus.flush = 1; bus.flush_store_cnt = 5'd5; bus.store_commit = 1;
        #1;
        chk("t5_flush", {bus.instr0_req, bus.instr1_req, bus.rnds_stall}, 3'b001);
        nxt();
        bus.flush = 0; bus.store_commit = 0;
        #1;
        chk("t5_fstate", {30'(bus.ctrl_state), bus.instr0_req, bus.instr1_req}, {30'd2, 2'b00});
        nxt();
        #1;
        chk("t5_resume", {bus.instr0_req, 4'(bus.instr0_store_id), 4'(bus.instr1_store_id)},
            {1'b1, 4'd5, 4'd6});
        chk("t5_cmt", 32'(dut.commit_ptr_q), 1);
        nxt();
        // Asynchronous reset in SERIAL_WAIT
        idle();
        bus.instr0_valid = 1; bus.instr0_is_serial = 1;
        nxt();
        idle();
        #1;
        chk("t6_pre", {28'(bus.ctrl_state), 4'(bus.instr0_store_id)}, {28'd1, 4'd7});
        #1 rst_n = 0;
        #1;
        chk("t6_state", 32'(bus.ctrl_state), 0);
        chk("t6_cnt", {dut.store_cnt_q, dut.commit_ptr_q, bus.instr0_store_id}, '0);
        nxt();
        rst_n = 1;
        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            inf = (m_cnt - m_cmt + 32) % 32;
            bus.instr0_valid     = ($urandom_range(0, 7) != 0);
            bus.instr1_valid     = ($urandom_range(0, 3) != 0);
            bus.instr0_is_mem    = 1'($urandom);
            bus.instr1_is_mem    = 1'($urandom);
            bus.instr0_is_store  = 1'($urandom);
            bus.instr1_is_store  = 1'($urandom);
            bus.instr0_is_serial = ($urandom_range(0, 11) == 0);
            bus.instr1_is_serial = ($urandom_range(0, 11) == 0);
            bus.rob_is_empty     = 1'($urandom);
            lvl_bits(bus.rob_instr0_check_top, bus.rob_instr1_check_top);
            lvl_bits(bus.int_iq_instr0_check_top, bus.int_iq_instr1_check_top);
            lvl_bits(bus.mem_iq_instr0_check_top, bus.mem_iq_instr1_check_top);
            bus.store_commit = (inf > 0) && ($urandom_range(0, 2) == 0);
            bus.flush        = ($urandom_range(0, 39) == 0);
            if (bus.store_commit)
                bus.flush_store_cnt = 5'((m_cmt + 1 + int'($urandom_range(0, inf - 1))) % 32);
            else
                bus.flush_store_cnt = 5'((m_cmt + int'($urandom_range(0, inf))) % 32);
            nxt();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
